// File: rtl/pipelined_shifter_if.sv
// Handshake bundle for the pipelined shifter: operation in on the in_* side,
// result out on the out_* side.
interface pipelined_shifter_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic [N-1:0]     in_shamt;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipelined_shifter.sv
// Logarithmic shifter (SLL/SRL/SRA/ROR) split into one register stage per
// shift-amount bit; the whole pipeline advances or stalls as one unit.
module pipelined_shifter #(
  parameter int unsigned N     = 32,
  parameter int unsigned TAG_W = 4
) (
  input logic               clk,
  input logic               rst,
  pipelined_shifter_if.slave bus
);
  localparam int unsigned LOG2N = $clog2(N);

  localparam logic [1:0] ModeSll = 2'b00;
  localparam logic [1:0] ModeSrl = 2'b01;
  localparam logic [1:0] ModeSra = 2'b10;

  // Shift one stage by a fixed power-of-two amount; amt is constant per stage.
  function automatic logic [N-1:0] shift_by(input logic [N-1:0] d, input logic [1:0] mode,
                                            input logic sign, input int unsigned amt);
    logic [N-1:0] fill;
    logic [N-1:0] res;
    fill = ~({N{1'b1}} >> amt);
    case (mode)
      ModeSll: res = d << amt;
      ModeSrl: res = d >> amt;
      ModeSra: res = (d >> amt) | (sign ? fill : '0);
      default: res = (d >> amt) | (d << (N - amt));
    endcase
    return res;
  endfunction

  logic adv;

  logic             sat;
  logic [N-1:0]     entry_data;
  logic [LOG2N-1:0] entry_shamt;

  logic [LOG2N-1:0] valid_q, valid_d;
  logic [LOG2N-1:0] sign_q, sign_d;
  logic [N-1:0]     data_q  [LOG2N];
  logic [N-1:0]     data_d  [LOG2N];
  logic [LOG2N-1:0] shamt_q [LOG2N];
  logic [LOG2N-1:0] shamt_d [LOG2N];
  logic [1:0]       mode_q  [LOG2N];
  logic [1:0]       mode_d  [LOG2N];
  logic [TAG_W-1:0] tag_q   [LOG2N];
  logic [TAG_W-1:0] tag_d   [LOG2N];

  assign adv = ~valid_q[LOG2N-1] | bus.out_ready;

  // Out-of-range amounts are resolved here so later stages only see LOG2N bits.
  always_comb begin
    sat         = |bus.in_shamt[N-1:LOG2N];
    entry_data  = bus.in_data;
    entry_shamt = bus.in_shamt[LOG2N-1:0];
    if (sat && (bus.in_mode != 2'b11)) begin
      entry_data  = (bus.in_mode == ModeSra) ? {N{bus.in_data[N-1]}} : '0;
      entry_shamt = '0;
    end
  end

  always_comb begin
    valid_d = '0;
    sign_d  = '0;
    data_d  = data_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    tag_d   = tag_q;

    valid_d[0] = bus.in_valid & adv;
    sign_d[0]  = bus.in_data[N-1];
    shamt_d[0] = entry_shamt;
    mode_d[0]  = bus.in_mode;
    tag_d[0]   = bus.in_tag;
    data_d[0]  = entry_shamt[0] ? shift_by(entry_data, bus.in_mode, bus.in_data[N-1], 1)
                                : entry_data;

    for (int k = 1; k < LOG2N; k++) begin
      valid_d[k] = valid_q[k-1];
      sign_d[k]  = sign_q[k-1];
      shamt_d[k] = shamt_q[k-1];
      mode_d[k]  = mode_q[k-1];
      tag_d[k]   = tag_q[k-1];
      data_d[k]  = shamt_q[k-1][k]
                   ? shift_by(data_q[k-1], mode_q[k-1], sign_q[k-1], int'(1) << k)
                   : data_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      sign_q  <= '0;
      for (int k = 0; k < LOG2N; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
        tag_q[k]   <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_d;
      sign_q  <= sign_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
    end
  end

  // The final stage's control fields have no consumer beyond the pipeline.
  logic unused_tail;
  assign unused_tail = ^{shamt_q[LOG2N-1], mode_q[LOG2N-1], sign_q[LOG2N-1]};

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[LOG2N-1];
  assign bus.out_data  = data_q[LOG2N-1];
  assign bus.out_tag   = tag_q[LOG2N-1];
endmodule
